frame_config_writer: RTL and testbench

- Configuration-side writer for the tile frame latches. It accepts a 32-bit configuration word stream over a valid/ready handshake.
- Stream format: a sync word, then {address word, data word} pairs.
- For each pair it drives FrameData, then pulses exactly one FrameStrobe line with setup and hold margins so the level-sensitive latches capture cleanly.
- Sits between the bitstream source (UART/SPI deserializer) and the fabric column frame buses.

---
 rtl/frame_cfg_pkg.sv | 21 ++
 rtl/frame_strobe_decoder.sv | 29 ++
 rtl/frame_config_writer.sv | 138 +++++++++++++
 tb/tb_frame_config_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the frame configuration writer: sync word, address word
// field positions and the writer state encoding.
package frame_cfg_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;

    localparam int unsigned DESYNC_BIT = 31;
    localparam int unsigned COL_LSB    = 16;
    localparam int unsigned COL_MSB    = 23;
    localparam int unsigned COL_W      = COL_MSB - COL_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        SETUP,
        STROBE,
        HOLD
    } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational {column, frame} to one-hot frame latch enable decoder; the parent registers
// the result.
module frame_strobe_decoder #(
    parameter int unsigned MaxFramesPerCol = 32,
    parameter int unsigned NumColumns      = 8,
    parameter int unsigned ColW            = 8,
    localparam int unsigned FrameW         = $clog2(MaxFramesPerCol),
    localparam int unsigned NumStrobes     = NumColumns * MaxFramesPerCol
) (
    input  logic [ColW-1:0]       col,
    input  logic [FrameW-1:0]     frame,
    input  logic                  en,
    output logic [NumStrobes-1:0] strobe
);

    logic [31:0] idx;

    assign idx = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);

    always_comb begin
        strobe = '0;
        for (int unsigned i = 0; i < NumStrobes; i++) begin
            if (en && (idx == i)) begin
                strobe[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Configuration word stream to frame latch writer: decodes sync/address/data words and pulses
// one FrameStrobe line per frame with a setup and a hold cycle around the pulse.
module frame_config_writer #(
    parameter int unsigned MaxFramesPerCol = 32,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumColumns      = 8,
    parameter int unsigned STROBE_CYCLES   = 2,
    parameter logic [FrameBitsPerRow-1:0] SYNC_WORD = frame_cfg_pkg::SYNC_WORD
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [FrameBitsPerRow-1:0]            WriteData,
    input  logic                                  WriteStrobe,
    output logic                                  WriteReady,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  Busy,
    output logic                                  Error,
    output logic [15:0]                           FrameCount
);

    import frame_cfg_pkg::*;

    localparam int unsigned FrameW     = $clog2(MaxFramesPerCol);
    localparam int unsigned NumStrobes = NumColumns * MaxFramesPerCol;

    localparam logic [COL_W:0]  ColLimit   = (COL_W + 1)'(NumColumns);
    localparam logic [FrameW:0] FrameLimit = (FrameW + 1)'(MaxFramesPerCol);
    localparam logic [3:0]      StrobeLast = 4'(STROBE_CYCLES - 1);

    state_e                 state_q;
    logic [COL_W-1:0]       col_q;
    logic [FrameW-1:0]      frame_q;
    logic                   in_range_q;
    logic [3:0]             cnt_q;

    logic                   accept;
    logic                   is_sync;
    logic [COL_W-1:0]       addr_col;
    logic [FrameW-1:0]      addr_frame;
    logic                   addr_ok;
    logic [NumStrobes-1:0]  strobe_dec;

    assign accept     = WriteStrobe & WriteReady;
    assign is_sync    = (WriteData == SYNC_WORD);
    assign addr_col   = WriteData[COL_MSB:COL_LSB];
    assign addr_frame = WriteData[FrameW-1:0];
    assign addr_ok    = ({1'b0, addr_col} < ColLimit) && ({1'b0, addr_frame} < FrameLimit);

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumColumns      (NumColumns),
        .ColW            (COL_W)
    ) u_decoder (
        .col    (col_q),
        .frame  (frame_q),
        .en     ((state_q == SETUP) && in_range_q),
        .strobe (strobe_dec)
    );

    // All outputs are registered here; the async reset drops FrameStrobe mid-pulse.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            frame_q     <= '0;
            in_range_q  <= 1'b0;
            cnt_q       <= '0;
            WriteReady  <= 1'b1;
            FrameData   <= '0;
            FrameStrobe <= '0;
            Busy        <= 1'b0;
            Error       <= 1'b0;
            FrameCount  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_sync) begin
                        state_q    <= ADDR;
                        Busy       <= 1'b1;
                        FrameCount <= '0;
                        Error      <= 1'b0;
                    end
                end
                ADDR: begin
                    if (accept && !is_sync) begin
                        if (WriteData[DESYNC_BIT]) begin
                            state_q <= IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            col_q      <= addr_col;
                            frame_q    <= addr_frame;
                            in_range_q <= addr_ok;
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (in_range_q) begin
                            FrameData  <= WriteData;
                            WriteReady <= 1'b0;
                            state_q    <= SETUP;
                        end else begin
                            Error   <= 1'b1;
                            state_q <= ADDR;
                        end
                    end
                end
                SETUP: begin
                    FrameStrobe <= strobe_dec;
                    cnt_q       <= StrobeLast;
                    state_q     <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        FrameStrobe <= '0;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    FrameCount <= FrameCount + 16'd1;
                    WriteReady <= 1'b1;
                    state_q    <= ADDR;
                end
                default: begin
                    state_q     <= IDLE;
                    WriteReady  <= 1'b1;
                    FrameStrobe <= '0;
                    Busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench for frame_config_writer: a stream-level model predicts frame writes and
// status; a negedge monitor checks every strobe pulse and ready gap against the prediction.
module tb_frame_config_writer;

    localparam int unsigned SC         = 2;
    localparam int unsigned NS         = 256;
    localparam logic [31:0] SYNC       = 32'hFAB0_FAB1;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   WriteData = '0;
    logic          WriteStrobe = 1'b0;
    logic          WriteReady;
    logic [31:0]   FrameData;
    logic [NS-1:0] FrameStrobe;
    logic          Busy;
    logic          Error;
    logic [15:0]   FrameCount;

    frame_config_writer #(
        .MaxFramesPerCol (32),
        .FrameBitsPerRow (32),
        .NumColumns      (8),
        .STROBE_CYCLES   (SC),
        .SYNC_WORD       (SYNC)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .WriteReady  (WriteReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Busy        (Busy),
        .Error       (Error),
        .FrameCount  (FrameCount)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
        int unsigned acc;
    } exp_t;
    exp_t exp_q[$];

    // Stream-level model of the session
    bit          m_sess = 0;
    bit          m_want_addr = 1;
    bit          m_ok = 0;
    int unsigned m_idx = 0;
    logic [31:0] m_fd = '0;
    logic [15:0] m_cnt = '0;
    bit          m_err = 0;

    task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sess = 0; m_want_addr = 1; m_ok = 0; m_fd = '0; m_cnt = '0; m_err = 0;
    endtask

    task automatic model_accept(input logic [31:0] w, input int unsigned acc);
        int unsigned col;
        int unsigned fr;
        if (!m_sess) begin
            if (w == SYNC) begin
                m_sess = 1; m_want_addr = 1; m_cnt = '0; m_err = 0;
            end
        end else if (m_want_addr) begin
            if (w == SYNC) begin
                // re-sync: nothing changes
            end else if (w[31]) begin
                m_sess = 0;
            end else begin
                col = int'(w[23:16]);
                fr = int'(w[4:0]);
                m_ok = (col < 8) && (fr < 32);
                m_idx = col * 32 + fr;
                m_want_addr = 0;
            end
        end else begin
            if (m_ok) begin
                m_fd = w;
                exp_q.push_back('{m_idx, w, acc});
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_err = 1;
            end
            m_want_addr = 1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        @(negedge CLK);
        WriteData = w;
        WriteStrobe = 1'b1;
        while (WriteReady !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (WriteReady !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got ready=%b expected 1 within 50 cycles", WriteReady);
            return;
        end
        model_accept(w, cyc + 1);
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        WriteStrobe = 1'b0;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic check_state(input string tag);
        idle(20);
        check({tag, "_count"}, NS'(FrameCount), NS'(m_cnt));
        check({tag, "_error"}, NS'(Error), NS'(m_err));
        check({tag, "_busy"}, NS'(Busy), NS'(m_sess));
        check({tag, "_fdata"}, NS'(FrameData), NS'(m_fd));
        check({tag, "_ready"}, NS'(WriteReady), NS'(1));
        check({tag, "_strobe"}, FrameStrobe, '0);
    endtask

    function automatic logic [31:0] rand_word();
        int k = int'($urandom_range(0, 99));
        if (k < 8) return SYNC;
        if (k < 13) return 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
        if (k < 55) return {1'b0, 7'($urandom), 8'($urandom_range(0, 7)), 11'($urandom), 5'($urandom)};
        if (k < 62) return {1'b0, 7'($urandom), 8'($urandom_range(8, 255)), 16'($urandom)};
        return $urandom;
    endfunction

    // Monitor: checks each strobe pulse against the scoreboard and each ready-low gap.
    bit          in_pulse = 0;
    int          plen = 0;
    int          rdy_low = 0;
    logic [31:0] cur_data = '0;
    logic [NS-1:0] prev_strobe = '0;

    always @(negedge CLK) begin
        exp_t e;
        logic [NS-1:0] ev;
        if (!resetn) begin
            in_pulse = 0;
            rdy_low = 0;
        end else begin
            if (FrameStrobe != '0) check("strobe_onehot", NS'($countones(FrameStrobe)), NS'(1));
            if (FrameStrobe != '0 && !in_pulse) begin
                in_pulse = 1;
                plen = 1;
                prev_strobe = FrameStrobe;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got %0h expected no strobe", FrameStrobe);
                    cur_data = FrameData;
                end else begin
                    e = exp_q.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    cur_data = e.data;
                    check("strobe_index", FrameStrobe, ev);
                    check("strobe_data", NS'(FrameData), NS'(e.data));
                    check("strobe_start", NS'(cyc), NS'(e.acc + 1));
                end
            end else if (in_pulse && FrameStrobe != '0) begin
                plen++;
                check("strobe_steady", FrameStrobe, prev_strobe);
                check("data_stable", NS'(FrameData), NS'(cur_data));
            end else if (in_pulse) begin
                check("strobe_len", NS'(plen), NS'(SC));
                check("hold_data", NS'(FrameData), NS'(cur_data));
                in_pulse = 0;
            end
            if (!WriteReady) begin
                rdy_low++;
            end else if (rdy_low > 0) begin
                check("ready_low_len", NS'(rdy_low), NS'(SC + 2));
                rdy_low = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        check("rst_fdata", NS'(FrameData), '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_busy", NS'(Busy), '0);
        check("rst_error", NS'(Error), '0);
        check("rst_count", NS'(FrameCount), '0);
        check("rst_ready", NS'(WriteReady), NS'(1));
        resetn = 1'b1;

        // Words before sync are discarded
        send_word(32'h0002_0005);
        send_word(32'hDEAD_BEEF);
        check_state("presync");
        send_word(SYNC);
        idle(2);
        check("sync_busy", NS'(Busy), NS'(1));

        send_word(32'h0002_0005);
        send_word(32'hDEAD_BEEF);
        check_state("first_pair");

        // Out-of-range column, then a good pair; error stays set
        send_word(32'h0008_0000);
        send_word(32'h0000_1234);
        check_state("oor");
        send_word(32'h0001_001F);
        send_word(32'h0BAD_F00D);
        check_state("after_oor");

        // Back-to-back pairs with the strobe held
        send_word(32'h0000_0000);
        send_word(32'h1111_1111);
        send_word(32'h0007_001F);
        send_word(32'h2222_2222);
        send_word(32'h0004_0010);
        send_word(32'h3333_3333);
        check_state("b2b");

        // Desync, then re-sync inside ADDR keeps the count
        send_word(32'h8000_0000);
        check_state("desync");
        send_word(SYNC);
        send_word(32'h0005_0003);
        send_word(32'h4444_4444);
        send_word(SYNC);
        check_state("resync");
        send_word(32'h0006_0002);
        send_word(32'h5555_5555);
        check_state("resync_pair");

        // Reset during the second strobe cycle
        send_word(32'h0003_0007);
        send_word(32'hA5A5_5A5A);
        @(negedge CLK);
        WriteStrobe = 1'b0;
        n = 0;
        while (FrameStrobe == '0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("midrst_strobe_seen", NS'(FrameStrobe != '0), NS'(1));
        @(posedge CLK);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_strobe", FrameStrobe, '0);
        check("midrst_fdata", NS'(FrameData), '0);
        check("midrst_busy", NS'(Busy), '0);
        check("midrst_error", NS'(Error), '0);
        check("midrst_count", NS'(FrameCount), '0);
        check("midrst_ready", NS'(WriteReady), NS'(1));
        model_reset();
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        send_word(SYNC);
        send_word(32'h0002_0005);
        send_word(32'hCAFE_0001);
        check_state("post_reset");

        // Randomized streams
        for (int r = 0; r < 4; r++) begin
            send_word(SYNC);
            for (int i = 0; i < 80; i++) begin
                send_word(rand_word());
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
            end
            check_state($sformatf("rand%0d", r));
        end

        check("scoreboard_empty", NS'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
